adc_seq: RTL and testbench
==========================

Name: adc_seq

Overview:
- Multi-cycle sequencer for wide add/subtract through one narrow ripple-carry slice (SLICE bits, SB_LUT4 sum plus SB_CARRY chain).
- Accepts WIDTH-bit operands on a valid/ready handshake and feeds them LSB-first one slice per cycle.
- Holds the inter-slice carry in a register, assembles the result and presents it on a valid/ready output.
- Sits between operand sources and consumers where area matters more than latency.

Parameters:
- WIDTH, 8, operand/result width; must be a multiple of SLICE and at least SLICE.
- SLICE, 2, bits per adder pass; NSLICE = WIDTH/SLICE passes per operation.

Ports:
- CLKIN  input  1  clock; all state updates on the rising edge.
- RESETN  input  1  synchronous, active-low reset.
- IN_VALID  input  1  operand request.
- IN_READY  output  1  high only in IDLE.
- A  input  WIDTH  minuend/addend.
- B  input  WIDTH  subtrahend/addend.
- SUB  input  1  1 = subtract, 0 = add.
- CIN  input  1  carry-in (add) or borrow-in (subtract).
- OUT_VALID  output  1  result available.
- OUT_READY  input  1  consumer accepts result.
- SUM  output  WIDTH  result.
- COUT  output  1  raw carry out of the MSB (subtract: 1 = no borrow).
- OVF  output  1  two's-complement overflow.
- BUSY  output  1  high in RUN or DONE.

Behaviour:
- Reset: RESETN=0 at an edge forces IDLE and clears all registers. OUT_VALID=0, SUM=0, COUT=0, OVF=0, BUSY=0, IN_READY=1 from the next cycle.
- Reset mid-RUN or mid-DONE aborts the operation; the pending result is discarded and never presented.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on IN_VALID & IN_READY. At that edge:
  - opa <= A.
  - opb <= SUB ? ~B : B.
  - carry <= SUB ? ~CIN : CIN.
  - idx <= 0.
  - Result of subtract is A - B - CIN.
  - A, B, SUB and CIN are sampled only at this edge.
- RUN, each cycle:
  - Slice adds opa[idx*SLICE +: SLICE], opb[same] and carry.
  - Slice sum is written to res[idx*SLICE +: SLICE]; carry <= slice carry-out; idx++.
  - The slice is purely combinational.
- RUN -> DONE when idx = NSLICE-1 completes, i.e. after exactly NSLICE RUN cycles.
  - At that edge: COUT <= final carry.
  - OVF <= (opa_msb == opb_msb) & (sum_msb != opa_msb), using the post-inversion opb.
- Latency: accept edge at cycle t gives OUT_VALID=1 from cycle t+NSLICE (4 cycles for defaults).
- DONE: OUT_VALID=1; SUM, COUT and OVF stable and held indefinitely while OUT_READY=0.
  - OUT_VALID & OUT_READY at an edge -> IDLE.
  - No new operand is accepted in the same cycle; IN_READY rises the cycle after the handoff.
  - Minimum issue interval is NSLICE+2 cycles.
- SUM, COUT and OVF are registered and change only on entry to DONE or on reset. Their value outside DONE is the last result (0 after reset), not valid data.
- IN_VALID while busy is ignored; the requester must hold its request.
- Width rules:
  - idx is ceil(log2(NSLICE)) bits, minimum 1.
  - All arithmetic is modulo 2^WIDTH; the carry register is 1 bit.
  - WIDTH == SLICE degenerates to a single RUN cycle.

Decomposition:
- Shared package:
  - state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - function clog2 for idx width.
  - constant DEFAULT_SLICE=2.
- One sub-module, adc_slice (SLICE-bit carry-in/carry-out ripple adder).
  - Built from per-bit LUT sum (16'h9696) plus SB_CARRY cells, instantiated once.
  - Controller, operand/result registers and handshake stay in adc_seq.

Test Plan (WIDTH=8, SLICE=2):
- Basic add: A=0x5A, B=0x3C, SUB=0, CIN=0 -> OUT_VALID 4 cycles after accept, SUM=0x96, COUT=0, OVF=1.
- Carry across all slices: A=0xFF, B=0x01, CIN=0 -> SUM=0x00, COUT=1, OVF=0. A=0xFF, B=0x00, CIN=1 -> SUM=0x00, COUT=1.
- Subtract: A=0x10, B=0x01, SUB=1, CIN=0 -> SUM=0x0F, COUT=1, OVF=0. A=0x00, B=0x01, SUB=1 -> SUM=0xFF, COUT=0, OVF=0. A=0x80, B=0x01, SUB=1 -> SUM=0x7F, OVF=1.
- Backpressure: hold OUT_READY=0 for 10 cycles -> OUT_VALID and SUM stable, IN_READY=0; IN_VALID toggling meanwhile is not accepted. Release -> IN_READY=1 exactly one cycle after the handoff.
- Reset mid-RUN: assert RESETN=0 at RUN idx=2 -> next cycle IDLE, OUT_VALID=0, SUM=0. No result emitted for the aborted operation; next operation computes correctly.
- Back-to-back stream: 20 random A/B/SUB/CIN with random OUT_READY stalls -> every result matches the reference model, in order, with no drops or duplicates.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// Shared definitions for the adc_seq multi-cycle add/subtract sequencer.
//   state_e       : controller state encoding (idle / run / done)
//   DEFAULT_SLICE : default number of bits handled per adder pass
//   clog2()       : index-register width helper, never narrower than 1 bit
package adc_seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_SLICE = 2;

  // Bits needed to count 0..n-1; a single-pass configuration still gets a 1-bit index.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/adc_slice.sv
// Narrow ripple-carry adder slice, purely combinational.
// Each bit is a LUT4 evaluating 16'h9696 (3-input XOR) for the sum and a
// carry cell computing majority(a, b, ci), mirroring an SB_LUT4 + SB_CARRY column.
//   a_i, b_i : Width-bit operands
//   ci_i     : carry into bit 0
//   s_o      : Width-bit sum
//   co_o     : carry out of the top bit
module adc_slice #(
  parameter int unsigned Width = 2
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             ci_i,
  output logic [Width-1:0] s_o,
  output logic             co_o
);

  localparam logic [15:0] SumLut = 16'h9696;

  logic [Width:0] c;

  assign c[0] = ci_i;

  for (genvar i = 0; i < Width; i++) begin : g_bit
    logic [3:0] lut_idx;
    // I3 is tied low; the 9696 pattern ignores it anyway.
    assign lut_idx  = {1'b0, c[i], b_i[i], a_i[i]};
    assign s_o[i]   = SumLut[lut_idx];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (a_i[i] & c[i]) | (b_i[i] & c[i]);
  end

  assign co_o = c[Width];

endmodule

// File: rtl/adc_seq.sv
// Wide add/subtract sequenced through one SLICE-bit adder, LSB slice first.
// Operands are taken on IN_VALID/IN_READY, one slice is summed per cycle with
// the inter-slice carry held in a register, and the result is offered on
// OUT_VALID/OUT_READY. Subtract is A + ~B + ~CIN, giving A - B - CIN.
//   CLKIN, RESETN         : clock, synchronous active-low reset
//   IN_VALID, IN_READY    : operand handshake (ready only while idle)
//   A, B, SUB, CIN        : operands, op select, carry/borrow in
//   OUT_VALID, OUT_READY  : result handshake
//   SUM, COUT, OVF        : result, raw MSB carry, two's-complement overflow
//   BUSY                  : operation in flight or result pending
module adc_seq
  import adc_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = DEFAULT_SLICE
) (
  input  logic             CLKIN,
  input  logic             RESETN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  input  logic             CIN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF,
  output logic             BUSY
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IdxW   = clog2(NSLICE);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NSLICE - 1);

  state_e           state_q;
  logic [WIDTH-1:0] opa_q, opb_q, res_q, res_d, sum_q;
  logic [IdxW-1:0]  idx_q;
  logic             carry_q, cout_q, ovf_q;

  logic [SLICE-1:0] sl_a, sl_b, sl_s;
  logic             sl_co;
  logic             ovf_d;

  assign sl_a = opa_q[idx_q*SLICE +: SLICE];
  assign sl_b = opb_q[idx_q*SLICE +: SLICE];

  adc_slice #(
    .Width(SLICE)
  ) u_slice (
    .a_i (sl_a),
    .b_i (sl_b),
    .ci_i(carry_q),
    .s_o (sl_s),
    .co_o(sl_co)
  );

  // Result with the current slice merged in; on the last pass this is the full sum.
  always_comb begin
    res_d = res_q;
    res_d[idx_q*SLICE +: SLICE] = sl_s;
  end

  // opb_q is already inverted for subtract, so the plain add-overflow rule holds.
  assign ovf_d = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) & (sl_s[SLICE-1] != opa_q[WIDTH-1]);

  always_ff @(posedge CLKIN) begin
    if (!RESETN) begin
      state_q <= StIdle;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (IN_VALID) begin
            opa_q   <= A;
            opb_q   <= SUB ? ~B : B;
            carry_q <= SUB ? ~CIN : CIN;
            idx_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          res_q   <= res_d;
          carry_q <= sl_co;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            sum_q   <= res_d;
            cout_q  <= sl_co;
            ovf_q   <= ovf_d;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (OUT_READY) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign IN_READY  = (state_q == StIdle);
  assign OUT_VALID = (state_q == StDone);
  assign BUSY      = (state_q != StIdle);
  assign SUM       = sum_q;
  assign COUT      = cout_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_adc_seq.sv
// Directed and stream checks for adc_seq at WIDTH=8, SLICE=2.
module tb_adc_seq;

  logic       CLKIN = 1'b0;
  logic       RESETN = 1'b0;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic [7:0] A = 8'h00;
  logic [7:0] B = 8'h00;
  logic       SUB = 1'b0;
  logic       CIN = 1'b0;
  logic       OUT_VALID;
  logic       OUT_READY = 1'b0;
  logic [7:0] SUM;
  logic       COUT;
  logic       OVF;
  logic       BUSY;

  int n_pass = 0;
  int n_fail = 0;
  int n_checks = 0;

  adc_seq #(
    .WIDTH(8),
    .SLICE(2)
  ) dut (
    .CLKIN    (CLKIN),
    .RESETN   (RESETN),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .A        (A),
    .B        (B),
    .SUB      (SUB),
    .CIN      (CIN),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .SUM      (SUM),
    .COUT     (COUT),
    .OVF      (OVF),
    .BUSY     (BUSY)
  );

  always #5 CLKIN = ~CLKIN;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLKIN);
    #1;
  endtask

  // Present one operand set and let it be accepted at the next edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic sub,
                       input logic cin);
    int k;
    k = 0;
    while (!IN_READY && k < 20) begin
      tick();
      k++;
    end
    check("in_ready_wait", 32'(IN_READY), 32'd1);
    A = a;
    B = b;
    SUB = sub;
    CIN = cin;
    IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!OUT_VALID && lat < 40) begin
      tick();
      lat++;
    end
    check("out_valid_wait", 32'(OUT_VALID), 32'd1);
  endtask

  task automatic directed(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic sub, input logic cin, input logic [7:0] esum,
                          input logic ecout, input logic eovf);
    int lat;
    issue(a, b, sub, cin);
    wait_valid(lat);
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_sum"}, 32'(SUM), 32'(esum));
    check({tag, "_cout"}, 32'(COUT), 32'(ecout));
    check({tag, "_ovf"}, 32'(OVF), 32'(eovf));
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    check({tag, "_ready_after"}, 32'(IN_READY), 32'd1);
    check({tag, "_valid_drop"}, 32'(OUT_VALID), 32'd0);
  endtask

  // Reference: signed/unsigned arithmetic on the original operands. Returns {cout, ovf, sum}.
  function automatic logic [9:0] ref_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic sub, input logic cin);
    int sa, sb, r, ua, ub, uc;
    logic [7:0] s;
    logic co, ov;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    uc = int'(cin);
    if (sub) begin
      r  = sa - sb - uc;
      co = (ua >= ub + uc);
      s  = 8'(ua - ub - uc);
    end else begin
      r  = sa + sb + uc;
      co = (ua + ub + uc > 255);
      s  = 8'(ua + ub + uc);
    end
    ov = (r > 127) || (r < -128);
    return {co, ov, s};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [7:0] ra, rb;
    logic rs, rc;
    logic [9:0] exp;
    logic saw_valid;

    // Reset state
    RESETN = 1'b0;
    repeat (3) tick();
    RESETN = 1'b1;
    check("rst_in_ready", 32'(IN_READY), 32'd1);
    check("rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_result", 32'({COUT, OVF, SUM}), 32'd0);

    // Directed vectors
    directed("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b1 ^ 1'b1, 1'b1);
    directed("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    directed("add_ff_00_c", 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    directed("sub_10_01", 8'h10, 8'h01, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b0);
    directed("sub_00_01", 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    directed("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
    directed("sub_10_01_b", 8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0);

    // Backpressure: result held, new requests ignored
    issue(8'h5A, 8'h3C, 1'b0, 1'b0);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      IN_VALID = i[0];
      A = 8'hFF;
      B = 8'hFF;
      check("bp_out_valid", 32'(OUT_VALID), 32'd1);
      check("bp_sum", 32'(SUM), 32'h96);
      check("bp_in_ready", 32'(IN_READY), 32'd0);
      tick();
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    check("bp_release_ready", 32'(IN_READY), 32'd1);
    check("bp_release_valid", 32'(OUT_VALID), 32'd0);
    tick();
    check("bp_no_accept", 32'(BUSY), 32'd0);

    // Reset in the middle of RUN (idx = 2)
    issue(8'h12, 8'h34, 1'b0, 1'b0);
    tick();
    tick();
    RESETN = 1'b0;
    tick();
    RESETN = 1'b1;
    check("mid_rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("mid_rst_sum", 32'(SUM), 32'd0);
    check("mid_rst_flags", 32'({COUT, OVF}), 32'd0);
    check("mid_rst_busy", 32'(BUSY), 32'd0);
    check("mid_rst_in_ready", 32'(IN_READY), 32'd1);
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      saw_valid = saw_valid | OUT_VALID;
      tick();
    end
    check("mid_rst_no_result", 32'(saw_valid), 32'd0);
    directed("after_rst", 8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0);

    // Stream with garbage requests while busy and random output stalls
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      rc = 1'($urandom);
      exp = ref_model(ra, rb, rs, rc);
      issue(ra, rb, rs, rc);
      IN_VALID = 1'b1;
      A = 8'($urandom);
      B = 8'($urandom);
      SUB = 1'($urandom);
      CIN = 1'($urandom);
      wait_valid(lat);
      check("stream_latency", 32'(lat), 32'd4);
      repeat ($urandom_range(0, 3)) begin
        check("stream_stall_hold", 32'({OUT_VALID, IN_READY, COUT, OVF, SUM}),
              32'({1'b1, 1'b0, exp}));
        tick();
      end
      check("stream_result", 32'({COUT, OVF, SUM}), 32'(exp));
      OUT_READY = 1'b1;
      tick();
      OUT_READY = 1'b0;
    end
    IN_VALID = 1'b0;
    tick();
    check("stream_idle_end", 32'(BUSY), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
